line_mem_responder: RTL and testbench
=====================================

Name: line_mem_responder

Overview:
- Responder end of the 128-bit line memory handshake (mem_read/mem_write/mem_addr[31:4]/mem_wdata/mem_rdata/mem_ready) that the L2 cache drives toward memory.
- Models a slow line-wide memory with programmable access latency. It is used as the D-side and I-side memory behind the L2 cache in block- and chip-level benches.
- It checks the initiator's handshake obligations and reports violations on a sticky error flag.

Parameters:
- LINE_W, 128, line width in bits; equals mem_wdata/mem_rdata width.
- DEPTH_LOG2, 8, log2 of the number of stored lines (default 256 lines).
- LATENCY, 8, cycles from request visible to mem_ready pulse; legal range 1..255.

Ports:
- clk  input  1  clock, all state on rising edge.
- proc_reset  input  1  asynchronous, active-high reset.
- mem_read  input  1  line read request, level, held until mem_ready.
- mem_write  input  1  line write request, level, held until mem_ready.
- mem_addr  input  28  line address (byte address bits 31:4).
- mem_wdata  input  LINE_W  write line data.
- mem_rdata  output  LINE_W  read line data, valid in the mem_ready cycle.
- mem_ready  output  1  one-cycle completion pulse.
- proto_err  output  1  sticky handshake-violation flag.

Behaviour:
- Reset (async assert, sampled deassert): FSM=IDLE, counter=0, mem_ready=0, mem_rdata=0, proto_err=0. Storage array is not reset; contents are undefined until written.
- Index = mem_addr[DEPTH_LOG2-1:0]. Upper address bits are ignored, so addresses alias modulo 2^DEPTH_LOG2 lines.
- States: IDLE, WAIT, RESP.
- IDLE: when mem_read|mem_write is high at a clock edge (request cycle 0), latch op, index, full address and wdata; load counter=LATENCY-1; go to WAIT. If LATENCY=1, go directly to RESP.
- Both read and write high at acceptance: treat as write and set proto_err.
- WAIT: decrement counter each cycle; when counter reaches 0, go to RESP. For reads, mem_rdata is loaded from the array on this transition.
- RESP: mem_ready=1 for exactly this one cycle (registered output), which is cycle LATENCY counted from request cycle 0.
  - Writes commit the latched wdata to the array at the end of RESP.
  - Next state is IDLE.
  - A request still high in the IDLE cycle after RESP is accepted as a new request; the initiator drops or changes its request on the edge where it samples mem_ready.
- Abort: if the latched op's request line is low at any edge while in WAIT, return to IDLE with no commit, no mem_ready pulse and no error.
- Mid-transaction change: while in WAIT/RESP, if mem_addr, the op, or mem_wdata (writes only) differs from the latched value, set proto_err. The transaction continues with the latched values.
- mem_rdata holds its last loaded value outside the ready cycle. Write transactions do not change mem_rdata.
- Read after write to the same index returns the new data; the write has committed before any later request is accepted.
- proto_err stays set until proc_reset.
- Reset mid-transaction: immediately back to IDLE, mem_ready low, and a pending write is not committed.
- Counter width is 8 bits; no wrap is possible within the legal LATENCY range.

Test Plan:
- LATENCY=8: write addr 0x0000010, wdata 0x0123…CDEF, hold until ready → mem_ready high only in cycle 8. Then read same addr → ready in cycle 8 of the read, mem_rdata=0x0123…CDEF, proto_err=0.
- LATENCY=1: back-to-back write A, write B, read A, read B with requests changed on the ready edge → each ready arrives one cycle after its request, and each read returns its own line.
- Aliasing, DEPTH_LOG2=8: write 0x0000105=X, then read 0x0000005 → returns X.
- Abort: issue a read, drop mem_read in cycle 3 → no mem_ready pulse. A new write issued in cycle 5 completes at cycle 5+LATENCY with correct data, proto_err=0.
- Violations: mem_read and mem_write high together → proto_err=1 and the line is written. Separately, after reset, change mem_addr in cycle 2 of a read → proto_err=1 and data returned from the originally latched address.
- Reset: assert proc_reset in cycle 4 of a write to 0x20 → outputs zero immediately. After release, reading 0x20 does not return the aborted data: it returns a previously written value or undefined.

Source files
------------

// File: rtl/line_mem_responder.sv
// Responder side of the 128-bit line memory handshake: a line-wide storage
// array with programmable access latency and a sticky handshake-violation flag.
module line_mem_responder #(
  parameter int LINE_W     = 128,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 8
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [27:0]       mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              proto_err,
  output logic [1:0]        dbg_state
);

  // Handshake: the initiator raises mem_read or mem_write (level) with stable
  // mem_addr/mem_wdata and holds them until it samples mem_ready high; the
  // transfer completes on that edge and the request may change right after it.
  // Dropping the request before mem_ready is an abort, not a violation.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t                  state, state_nxt;
  logic [7:0]              cnt;
  logic                    lat_wr;
  logic [27:0]             lat_addr;
  logic [LINE_W-1:0]       lat_wdata;
  logic [LINE_W-1:0]       mem [0:(1 << DEPTH_LOG2) - 1];

  logic                    req;
  logic                    req_held;
  logic                    accept;
  logic                    to_resp;
  logic                    rd_op;
  logic                    chg_err;
  logic [DEPTH_LOG2-1:0]   rd_idx;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = mem_read | mem_write;
    req_held  = lat_wr ? mem_write : mem_read;
    accept    = (state == IDLE) && req;
    case (state)
      IDLE: if (req) state_nxt = (LAT_M1 == 8'd0) ? RESP : WAIT;
      WAIT: begin
        if (!req_held)          state_nxt = IDLE;
        else if (cnt == 8'd1)   state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    to_resp = (state_nxt == RESP);
    // With single-cycle latency the read is served straight from the live request.
    rd_op   = (state == IDLE) ? !mem_write : !lat_wr;
    rd_idx  = (state == IDLE) ? mem_addr[DEPTH_LOG2-1:0] : lat_addr[DEPTH_LOG2-1:0];
    chg_err = (state != IDLE) && req_held &&
              ((mem_addr != lat_addr) ||
               (lat_wr ? mem_read : mem_write) ||
               (lat_wr && (mem_wdata != lat_wdata)));
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      cnt       <= 8'd0;
      lat_wr    <= 1'b0;
      lat_addr  <= 28'd0;
      lat_wdata <= '0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      mem_ready <= to_resp;
      if (accept) begin
        lat_wr    <= mem_write;
        lat_addr  <= mem_addr;
        lat_wdata <= mem_wdata;
        cnt       <= LAT_M1;
        if (mem_read && mem_write) proto_err <= 1'b1;
      end else if (state == WAIT) begin
        cnt <= cnt - 8'd1;
      end
      if (to_resp && rd_op) mem_rdata <= mem[rd_idx];
      if (chg_err) proto_err <= 1'b1;
    end
  end

  // Storage is not reset; a write commits only when RESP actually completes.
  always_ff @(posedge clk) begin
    if (state == RESP && lat_wr) mem[lat_addr[DEPTH_LOG2-1:0]] <= lat_wdata;
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: one instance at LATENCY=8 and one at LATENCY=1,
// directed transactions with a queue-based scoreboard on mem_ready.
module tb_line_mem_responder;

  typedef struct {
    int           cyc;
    logic         is_rd;
    logic [127:0] data;
  } exp_t;

  logic         clk;
  logic         rst   [2];
  logic         rd    [2];
  logic         wr    [2];
  logic [27:0]  addr  [2];
  logic [127:0] wdata [2];
  logic [127:0] rdata [2];
  logic         ready [2];
  logic         err   [2];
  logic [1:0]   dbg   [2];

  int   cyc;
  int   checks;
  int   fails;
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DX = 128'hA5A5A5A5_11112222_33334444_5A5A5A5A;
  localparam logic [127:0] D3 = 128'hDEADBEEF_CAFEF00D_00000003_33333333;
  localparam logic [127:0] D4 = 128'h44444444_44444444_44444444_44444444;
  localparam logic [127:0] D5 = 128'h55555555_00000000_55555555_00000005;
  localparam logic [127:0] D6 = 128'h66666666_12345678_9ABCDEF0_00000006;
  localparam logic [127:0] D7 = 128'h77777777_77777777_00000000_00000007;
  localparam logic [127:0] D8 = 128'h88888888_00000000_88888888_00000008;
  localparam logic [127:0] DA = 128'hAAAAAAAA_00000001_AAAAAAAA_0000000A;
  localparam logic [127:0] DB = 128'hBBBBBBBB_00000002_BBBBBBBB_0000000B;

  line_mem_responder #(.LINE_W(128), .DEPTH_LOG2(8), .LATENCY(8)) u_dut8 (
    .clk(clk), .proc_reset(rst[0]), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
    .mem_ready(ready[0]), .proto_err(err[0]), .dbg_state(dbg[0])
  );

  line_mem_responder #(.LINE_W(128), .DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .proc_reset(rst[1]), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
    .mem_ready(ready[1]), .proto_err(err[1]), .dbg_state(dbg[1])
  );

  // Clock / reset / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat(input int k);
    return (k == 0) ? 8 : 1;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every mem_ready pulse must match the front of the expected queue.
  task automatic mon(input int k);
    exp_t e;
    if (ready[k] !== 1'b1) return;
    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
      checks++;
      fails++;
      $display("FAIL unexpected_ready dut%0d: mem_ready=1 at cycle %0d expected no pulse", k, cyc);
      return;
    end
    if (k == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
    checks++;
    if (cyc != e.cyc) begin
      fails++;
      $display("FAIL ready_cycle dut%0d: got cycle %0d expected cycle %0d", k, cyc, e.cyc);
    end
    if (e.is_rd) begin
      checks++;
      if (rdata[k] !== e.data) begin
        fails++;
        $display("FAIL rdata dut%0d: got %h expected %h", k, rdata[k], e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Driver tasks
  task automatic idle(input int k);
    rd[k] = 1'b0;
    wr[k] = 1'b0;
  endtask

  task automatic start(input int k, input logic r, input logic w,
                       input logic [27:0] a, input logic [127:0] d);
    rd[k] = r;
    wr[k] = w;
    addr[k] = a;
    wdata[k] = d;
  endtask

  task automatic push(input int k, input logic is_rd, input logic [127:0] d);
    exp_t e;
    e.cyc = cyc + lat(k);
    e.is_rd = is_rd;
    e.data = d;
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Hold the request until mem_ready is sampled, then return just after that edge.
  task automatic wait_ready(input int k);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (ready[k] === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout dut%0d: no mem_ready within 400 cycles", k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_line(input int k, input logic [27:0] a, input logic [127:0] d);
    start(k, 1'b0, 1'b1, a, d);
    push(k, 1'b0, '0);
    wait_ready(k);
  endtask

  task automatic read_line(input int k, input logic [27:0] a, input logic [127:0] exp_d);
    start(k, 1'b1, 1'b0, a, '0);
    push(k, 1'b1, exp_d);
    wait_ready(k);
  endtask

  task automatic do_reset(input int k);
    @(posedge clk);
    #1;
    rst[k] = 1'b1;
    idle(k);
    repeat (2) @(posedge clk);
    #1;
    rst[k] = 1'b0;
  endtask

  task automatic chk_reset_outputs(input int k);
    chk($sformatf("reset_ready dut%0d", k), {127'd0, ready[k]}, 128'd0);
    chk($sformatf("reset_rdata dut%0d", k), rdata[k], 128'd0);
    chk($sformatf("reset_err dut%0d", k), {127'd0, err[k]}, 128'd0);
    chk($sformatf("reset_state dut%0d", k), {126'd0, dbg[k]}, 128'd0);
  endtask

  initial begin
    checks = 0;
    fails = 0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      idle(k);
      addr[k] = '0;
      wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // LATENCY=1: back-to-back, request changed on each ready edge
    write_line(1, 28'h0000003, DA);
    write_line(1, 28'h000007F, DB);
    read_line(1, 28'h0000003, DA);
    read_line(1, 28'h000007F, DB);
    idle(1);
    chk("l1_err", {127'd0, err[1]}, 128'd0);

    // LATENCY=8: basic write then read, aliasing, preload lines
    write_line(0, 28'h0000010, D1);
    read_line(0, 28'h0000010, D1);
    idle(0);
    chk("basic_err", {127'd0, err[0]}, 128'd0);
    write_line(0, 28'h0000105, DX);
    read_line(0, 28'h0000005, DX);
    write_line(0, 28'h0000020, D5);
    write_line(0, 28'h0000050, D7);
    write_line(0, 28'h0000051, D8);
    idle(0);

    // Abort: read dropped in cycle 3 (no pulse), new write issued in cycle 5
    start(0, 1'b1, 1'b0, 28'h0000010, '0);
    repeat (3) @(posedge clk);
    #1;
    idle(0);
    repeat (2) @(posedge clk);
    #1;
    write_line(0, 28'h0000030, D3);
    read_line(0, 28'h0000030, D3);
    idle(0);
    chk("abort_err", {127'd0, err[0]}, 128'd0);

    // Reset in cycle 4 of a write to 0x20: outputs clear at once, no commit
    start(0, 1'b0, 1'b1, 28'h0000020, D4);
    repeat (4) @(posedge clk);
    #2;
    rst[0] = 1'b1;
    #1;
    chk_reset_outputs(0);
    idle(0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    read_line(0, 28'h0000020, D5);
    idle(0);
    chk("post_reset_err", {127'd0, err[0]}, 128'd0);

    // Read and write together: treated as write, flag set
    start(0, 1'b1, 1'b1, 28'h0000040, D6);
    push(0, 1'b0, '0);
    wait_ready(0);
    read_line(0, 28'h0000040, D6);
    idle(0);
    chk("both_err", {127'd0, err[0]}, 128'd1);

    // Address changed in cycle 2 of a read: flag set, original line returned
    do_reset(0);
    chk("cleared_err", {127'd0, err[0]}, 128'd0);
    start(0, 1'b1, 1'b0, 28'h0000050, '0);
    push(0, 1'b1, D7);
    repeat (2) @(posedge clk);
    #1;
    addr[0] = 28'h0000051;
    wait_ready(0);
    idle(0);
    chk("addr_chg_err", {127'd0, err[0]}, 128'd1);

    repeat (12) @(posedge clk);
    chk("queue_empty dut0", 128'(exp_q0.size()), 128'd0);
    chk("queue_empty dut1", 128'(exp_q1.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
